// File: rtl/match_table_pkg.sv
// rtl/match_table_pkg.sv - shared entry type and sizing helper for match_table
package match_table_pkg;

    // Entry fields are sized for the widest supported configuration; narrower
    // instances zero-extend on write and truncate on read.
    localparam int ENTRY_IP_W = 64;
    localparam int ENTRY_OP_W = 32;

    typedef struct packed {
        logic                  vld;
        logic [ENTRY_IP_W-1:0] mask;
        logic [ENTRY_IP_W-1:0] value;
        logic [ENTRY_OP_W-1:0] result;
    } entry_t;

    function automatic int calc_idx_w(input int depth);
        int w;
        w = $clog2(depth);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/match_table_priority_encoder.sv
// rtl/match_table_priority_encoder.sv - lowest-index-wins priority encoder
module priority_encoder
    import match_table_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int IDX_W = calc_idx_w(WIDTH)
) (
    input  logic [WIDTH-1:0] req,
    output logic [IDX_W-1:0] idx,
    output logic             found
);

    // Scanning downward lets the lowest set bit overwrite any higher one.
    always_comb begin
        idx   = '0;
        found = 1'b0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (req[i]) begin
                idx   = IDX_W'(i);
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/match_table.sv
// rtl/match_table.sv - masked ternary match table with one registered output stage
module match_table
    import match_table_pkg::*;
#(
    parameter int                  IP_WIDTH    = 10,
    parameter int                  OP_WIDTH    = 4,
    parameter int                  DEPTH       = 4,
    parameter logic [OP_WIDTH-1:0] MISS_RESULT = '0,
    localparam int                 IDX_W       = calc_idx_w(DEPTH)
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                clr_i,
    input  logic                wr_en_i,
    input  logic [IDX_W-1:0]    wr_idx_i,
    input  logic                wr_vld_i,
    input  logic [IP_WIDTH-1:0] wr_mask_i,
    input  logic [IP_WIDTH-1:0] wr_value_i,
    input  logic [OP_WIDTH-1:0] wr_result_i,
    input  logic [IP_WIDTH-1:0] in_i,
    input  logic                in_valid_i,
    output logic                in_ready_o,
    output logic [OP_WIDTH-1:0] out_o,
    output logic                hit_o,
    output logic [IDX_W-1:0]    hit_idx_o,
    output logic                out_valid_o,
    input  logic                out_ready_i
);

    // Every entry is compared in parallel each cycle, so the table lives in flops.
    entry_t                tbl_q [DEPTH];
    logic [ENTRY_IP_W-1:0] in_ext;
    logic [DEPTH-1:0]      hit_vec;
    logic [IDX_W-1:0]      win_idx;
    logic                  win_found;
    logic [OP_WIDTH-1:0]   win_result;
    logic                  in_xfer;

    assign in_ext     = ENTRY_IP_W'(in_i);
    assign in_ready_o = !out_valid_o || out_ready_i;
    assign in_xfer    = in_valid_i && in_ready_o;

    always_comb begin
        hit_vec = '0;
        for (int e = 0; e < DEPTH; e++) begin
            hit_vec[e] = tbl_q[e].vld &&
                         (((in_ext ^ tbl_q[e].value) & tbl_q[e].mask) == '0);
        end
    end

    priority_encoder #(
        .WIDTH (DEPTH),
        .IDX_W (IDX_W)
    ) u_prio (
        .req   (hit_vec),
        .idx   (win_idx),
        .found (win_found)
    );

    always_comb begin
        win_result = MISS_RESULT;
        for (int e = 0; e < DEPTH; e++) begin
            if (win_found && (win_idx == IDX_W'(e))) begin
                win_result = OP_WIDTH'(tbl_q[e].result);
            end
        end
    end

    // Write takes precedence over clear on its own entry; indices past DEPTH match nothing.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int e = 0; e < DEPTH; e++) begin
                tbl_q[e] <= '0;
            end
        end else begin
            for (int e = 0; e < DEPTH; e++) begin
                if (wr_en_i && (wr_idx_i == IDX_W'(e))) begin
                    tbl_q[e] <= '{vld:    wr_vld_i,
                                  mask:   ENTRY_IP_W'(wr_mask_i),
                                  value:  ENTRY_IP_W'(wr_value_i),
                                  result: ENTRY_OP_W'(wr_result_i)};
                end else if (clr_i) begin
                    tbl_q[e].vld <= 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            out_valid_o <= 1'b0;
            out_o       <= MISS_RESULT;
            hit_o       <= 1'b0;
            hit_idx_o   <= '0;
        end else if (in_xfer) begin
            out_valid_o <= 1'b1;
            out_o       <= win_result;
            hit_o       <= win_found;
            hit_idx_o   <= win_found ? win_idx : '0;
        end else if (out_ready_i) begin
            out_valid_o <= 1'b0;
        end
    end

endmodule

// File: tb/tb_match_table.sv
// tb/tb_match_table.sv - self-checking bench for match_table against a table-search model
module tb_match_table;

    localparam int             IPW   = 10;
    localparam int             OPW   = 4;
    localparam int             DEPTH = 5;
    localparam int             IDXW  = 3;
    localparam logic [OPW-1:0] MISS  = 4'hA;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            rst = 1'b1, clr = 1'b0, wr_en = 1'b0, wr_vld = 1'b0;
    logic            in_valid = 1'b0, out_ready = 1'b0;
    logic [IDXW-1:0] wr_idx = '0;
    logic [IPW-1:0]  wr_mask = '0, wr_value = '0, in_w = '0;
    logic [OPW-1:0]  wr_result = '0;
    logic            in_ready, hit, out_valid;
    logic [OPW-1:0]  out;
    logic [IDXW-1:0] hit_idx;

    int checks = 0;
    int failures = 0;

    // Reference state: the table as the spec describes it, plus the expected output register.
    logic           m_vld [8];
    logic [IPW-1:0] m_mask [8];
    logic [IPW-1:0] m_value [8];
    logic [OPW-1:0] m_result [8];
    logic           e_valid = 1'b0, e_hit = 1'b0;
    logic [OPW-1:0] e_out = MISS;
    logic [IDXW-1:0] e_idx = '0;

    match_table #(
        .IP_WIDTH    (IPW),
        .OP_WIDTH    (OPW),
        .DEPTH       (DEPTH),
        .MISS_RESULT (MISS)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .clr_i       (clr),
        .wr_en_i     (wr_en),
        .wr_idx_i    (wr_idx),
        .wr_vld_i    (wr_vld),
        .wr_mask_i   (wr_mask),
        .wr_value_i  (wr_value),
        .wr_result_i (wr_result),
        .in_i        (in_w),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready),
        .out_o       (out),
        .hit_o       (hit),
        .hit_idx_o   (hit_idx),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready)
    );

    function automatic void model_lookup(input logic [IPW-1:0] w, output logic h,
                                         output logic [OPW-1:0] r, output logic [IDXW-1:0] i);
        h = 1'b0; r = MISS; i = '0;
        for (int e = 0; e < DEPTH; e++) begin
            if (!h && m_vld[e] && (((w ^ m_value[e]) & m_mask[e]) == '0)) begin
                h = 1'b1; r = m_result[e]; i = IDXW'(e);
            end
        end
    endfunction

    task automatic step();
        logic h; logic [OPW-1:0] r; logic [IDXW-1:0] i;
        logic rdy;
        rdy = !e_valid || out_ready;
        if (rst) begin
            e_valid = 1'b0; e_hit = 1'b0; e_out = MISS; e_idx = '0;
            for (int e = 0; e < 8; e++) begin
                m_vld[e] = 1'b0; m_mask[e] = '0; m_value[e] = '0; m_result[e] = '0;
            end
        end else begin
            if (in_valid && rdy) begin
                model_lookup(in_w, h, r, i);
                e_valid = 1'b1; e_hit = h; e_out = r; e_idx = i;
            end else if (out_ready) begin
                e_valid = 1'b0;
            end
            if (clr) for (int e = 0; e < 8; e++) m_vld[e] = 1'b0;
            if (wr_en && (int'(wr_idx) < DEPTH)) begin
                m_vld[wr_idx] = wr_vld; m_mask[wr_idx] = wr_mask;
                m_value[wr_idx] = wr_value; m_result[wr_idx] = wr_result;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic write_entry(input logic [IDXW-1:0] idx, input logic v, input logic [IPW-1:0] mk,
                               input logic [IPW-1:0] vl, input logic [OPW-1:0] rs);
        wr_en = 1'b1; wr_idx = idx; wr_vld = v; wr_mask = mk; wr_value = vl; wr_result = rs;
        step();
        wr_en = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b want=0", out_valid); end
        checks++; if (out !== MISS) begin failures++; $display("FAIL reset_out got=%h want=%h", out, MISS); end
        checks++; if ({hit, hit_idx} !== 4'b0) begin failures++; $display("FAIL reset_hit got=%b/%0d want=0/0", hit, hit_idx); end
        rst = 1'b0; out_ready = 1'b0;
        #1;
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b want=1", in_ready); end
    endtask

    task automatic test_miss_after_reset();
        out_ready = 1'b1; in_valid = 1'b1; in_w = 10'h082;
        step();
        in_valid = 1'b0;
        checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL first_valid got=%b want=1", out_valid); end
        checks++; if ({hit, out} !== {1'b0, MISS}) begin failures++; $display("FAIL first_miss got=%b/%h want=0/%h", hit, out, MISS); end
        step();
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL drain_valid got=%b want=0", out_valid); end
    endtask

    task automatic test_mask_match();
        logic [IPW-1:0] words [3];
        logic           want_hit [3];
        words = '{10'h082, 10'h382, 10'h083};
        want_hit = '{1'b1, 1'b1, 1'b0};
        write_entry(3'd1, 1'b1, 10'h0C3, 10'h082, 4'd5);
        in_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            in_w = words[k];
            step();
            checks++;
            if (want_hit[k] && ({out_valid, hit, hit_idx, out} !== {1'b1, 1'b1, 3'd1, 4'd5})) begin
                failures++; $display("FAIL mask_hit in=%h got v=%b h=%b idx=%0d out=%h want 1/1/1/5", words[k], out_valid, hit, hit_idx, out);
            end else if (!want_hit[k] && ({out_valid, hit, hit_idx, out} !== {1'b1, 1'b0, 3'd0, MISS})) begin
                failures++; $display("FAIL mask_miss in=%h got v=%b h=%b idx=%0d out=%h want 1/0/0/%h", words[k], out_valid, hit, hit_idx, out, MISS);
            end
        end
        in_valid = 1'b0;
        step();
    endtask

    task automatic test_stall();
        out_ready = 1'b0; in_valid = 1'b1; in_w = 10'h082;
        step();
        in_w = 10'h083;
        for (int k = 0; k < 3; k++) begin
            #1;
            checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL stall_ready cyc=%0d got=%b want=0", k, in_ready); end
            step();
            checks++;
            if ({out_valid, hit, hit_idx, out} !== {1'b1, 1'b1, 3'd1, 4'd5}) begin
                failures++; $display("FAIL stall_hold cyc=%0d got v=%b h=%b idx=%0d out=%h want 1/1/1/5", k, out_valid, hit, hit_idx, out);
            end
        end
        out_ready = 1'b1;
        #1;
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL release_ready got=%b want=1", in_ready); end
        step();
        in_valid = 1'b0;
        checks++;
        if ({out_valid, hit, out} !== {1'b1, 1'b0, MISS}) begin
            failures++; $display("FAIL release_next got v=%b h=%b out=%h want 1/0/%h", out_valid, hit, out, MISS);
        end
        step();
    endtask

    task automatic test_priority_wildcard();
        write_entry(3'd0, 1'b1, 10'h000, 10'h3FF, 4'd9);
        in_valid = 1'b1; in_w = 10'h082;
        step();
        checks++; if ({hit, hit_idx, out} !== {1'b1, 3'd0, 4'd9}) begin failures++; $display("FAIL prio_082 got h=%b idx=%0d out=%h want 1/0/9", hit, hit_idx, out); end
        in_w = 10'h2D1;
        step();
        in_valid = 1'b0;
        checks++; if ({hit, hit_idx, out} !== {1'b1, 3'd0, 4'd9}) begin failures++; $display("FAIL wildcard got h=%b idx=%0d out=%h want 1/0/9", hit, hit_idx, out); end
        step();
    endtask

    task automatic test_write_same_cycle();
        clr = 1'b1;
        step();
        clr = 1'b0;
        wr_en = 1'b1; wr_idx = 3'd2; wr_vld = 1'b1; wr_mask = 10'h3FF; wr_value = 10'h155; wr_result = 4'd3;
        in_valid = 1'b1; in_w = 10'h155;
        step();
        wr_en = 1'b0;
        checks++; if ({out_valid, hit, out} !== {1'b1, 1'b0, MISS}) begin failures++; $display("FAIL same_cycle_write got v=%b h=%b out=%h want 1/0/%h", out_valid, hit, out, MISS); end
        step();
        in_valid = 1'b0;
        checks++; if ({hit, hit_idx, out} !== {1'b1, 3'd2, 4'd3}) begin failures++; $display("FAIL next_cycle_write got h=%b idx=%0d out=%h want 1/2/3", hit, hit_idx, out); end
        step();
    endtask

    task automatic test_clear_and_write();
        logic [IPW-1:0] words [3];
        logic [4:0]     want [3];
        write_entry(3'd1, 1'b1, 10'h0C3, 10'h082, 4'd5);
        out_ready = 1'b0; in_valid = 1'b1; in_w = 10'h155;
        step();
        in_valid = 1'b0; clr = 1'b1;
        wr_en = 1'b1; wr_idx = 3'd0; wr_vld = 1'b1; wr_mask = 10'h3FF; wr_value = 10'h0AA; wr_result = 4'd7;
        step();
        clr = 1'b0; wr_en = 1'b0;
        checks++; if ({out_valid, hit, hit_idx, out} !== {1'b1, 1'b1, 3'd2, 4'd3}) begin failures++; $display("FAIL clr_keeps_out got v=%b h=%b idx=%0d out=%h want 1/1/2/3", out_valid, hit, hit_idx, out); end
        out_ready = 1'b1;
        step();
        words = '{10'h155, 10'h082, 10'h0AA};
        want = '{{1'b0, MISS}, {1'b0, MISS}, {1'b1, 4'd7}};
        in_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            in_w = words[k];
            step();
            checks++; if ({hit, out} !== want[k]) begin failures++; $display("FAIL clr_write in=%h got h=%b out=%h want %b/%h", words[k], hit, out, want[k][4], want[k][3:0]); end
        end
        out_ready = 1'b0; in_w = 10'h0AA;
        step();
        in_valid = 1'b0; rst = 1'b1;
        step();
        rst = 1'b0;
        checks++; if ({out_valid, hit, out} !== {1'b0, 1'b0, MISS}) begin failures++; $display("FAIL rst_stall got v=%b h=%b out=%h want 0/0/%h", out_valid, hit, out, MISS); end
        out_ready = 1'b1; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        checks++; if ({out_valid, hit, out} !== {1'b1, 1'b0, MISS}) begin failures++; $display("FAIL rst_empty got v=%b h=%b out=%h want 1/0/%h", out_valid, hit, out, MISS); end
        step();
    endtask

    task automatic test_ignored_write();
        for (int k = 5; k < 8; k++) write_entry(IDXW'(k), 1'b1, 10'h000, 10'h000, 4'd1);
        in_valid = 1'b1; in_w = 10'h3C5;
        step();
        checks++; if ({hit, out} !== {1'b0, MISS}) begin failures++; $display("FAIL oob_write got h=%b out=%h want 0/%h", hit, out, MISS); end
        in_valid = 1'b0;
        write_entry(3'd4, 1'b1, 10'h000, 10'h000, 4'hC);
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        checks++; if ({hit, hit_idx, out} !== {1'b1, 3'd4, 4'hC}) begin failures++; $display("FAIL last_entry got h=%b idx=%0d out=%h want 1/4/c", hit, hit_idx, out); end
        step();
    endtask

    task automatic test_random();
        for (int n = 0; n < 600; n++) begin
            rst       = ($urandom_range(0, 79) == 0);
            clr       = ($urandom_range(0, 29) == 0);
            wr_en     = ($urandom_range(0, 3) == 0);
            wr_idx    = IDXW'($urandom_range(0, 7));
            wr_vld    = ($urandom_range(0, 4) != 0);
            wr_mask   = IPW'($urandom) & IPW'($urandom) & IPW'($urandom);
            wr_value  = IPW'($urandom);
            wr_result = OPW'($urandom);
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 1) == 0) in_w = m_value[$urandom_range(0, DEPTH - 1)] ^ IPW'($urandom & $urandom & $urandom);
            else in_w = IPW'($urandom);
            #1;
            checks++; if (in_ready !== (!e_valid || out_ready)) begin failures++; $display("FAIL rnd_ready n=%0d got=%b want=%b", n, in_ready, !e_valid || out_ready); end
            step();
            checks++; if (out_valid !== e_valid) begin failures++; $display("FAIL rnd_valid n=%0d got=%b want=%b", n, out_valid, e_valid); end
            if (e_valid) begin
                checks++;
                if ({hit, hit_idx, out} !== {e_hit, e_idx, e_out}) begin
                    failures++; $display("FAIL rnd_result n=%0d got h=%b idx=%0d out=%h want h=%b idx=%0d out=%h", n, hit, hit_idx, out, e_hit, e_idx, e_out);
                end
            end
        end
        rst = 1'b0; clr = 1'b0; wr_en = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        step();
    endtask

    initial begin
        test_reset();
        test_miss_after_reset();
        test_mask_match();
        test_stall();
        test_priority_wildcard();
        test_write_same_cycle();
        test_clear_and_write();
        test_ignored_write();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/match_table.md
MATCH_TABLE -- requirements
Module: match_table

Interface
REQ-001 SHALL provide parameter IP_WIDTH, default 10: width of the compared input word.
REQ-002 SHALL provide parameter OP_WIDTH, default 4: width of the result code.
REQ-003 SHALL provide parameter DEPTH, default 4: number of table entries, with a legal range of 1..64.
REQ-004 SHALL provide parameter MISS_RESULT, default 0, OP_WIDTH bits: result code driven when no entry matches.
REQ-005 SHALL derive localparam IDX_W as max(1, clog2(DEPTH)).
REQ-006 SHALL have these ports: clk_i  input  1  single clock, all logic on its rising edge.
REQ-007 SHALL have rst_i  input  1  reset, synchronous and active-high.
REQ-008 SHALL have clr_i  input  1  invalidates all entries.
REQ-009 SHALL have wr_en_i  input  1  table write strobe.
REQ-010 SHALL have wr_idx_i  input  IDX_W  entry index to write.
REQ-011 SHALL have wr_vld_i  input  1  valid bit written into the entry.
REQ-012 SHALL have wr_mask_i  input  IP_WIDTH  compare-enable mask.
REQ-013 SHALL have wr_value_i  input  IP_WIDTH  expected bit values.
REQ-014 SHALL have wr_result_i  input  OP_WIDTH  result code on match.
REQ-015 SHALL have in_i  input  IP_WIDTH  lookup word.
REQ-016 SHALL have in_valid_i  input  1  lookup request valid.
REQ-017 SHALL have in_ready_o  output  1  lookup request accepted.
REQ-018 SHALL have out_o  output  OP_WIDTH  registered result.
REQ-019 SHALL have hit_o  output  1  registered hit flag.
REQ-020 SHALL have hit_idx_o  output  IDX_W  registered index of the winning entry.
REQ-021 SHALL have out_valid_o  output  1  result valid.
REQ-022 SHALL have out_ready_i  input  1  result consumed.

Function
REQ-023 Entry e SHALL match when valid[e] is set and ((in_i XOR value[e]) AND mask[e]) is zero; a zero mask matches any input.
REQ-024 Match selection SHALL be fixed priority, with the lowest matching index winning.
REQ-025 On a hit, the output register SHALL load out_o = result[winner], hit_o = 1, hit_idx_o = winner.
REQ-026 On a miss, the output register SHALL load out_o = MISS_RESULT, hit_o = 0, hit_idx_o = 0.
REQ-027 The lookup handshake SHALL be: a transfer occurs when in_valid_i and in_ready_o are both high, and in_ready_o = !out_valid_o | out_ready_i (combinational, single output stage).
REQ-028 Latency SHALL be exactly 1 cycle: out_valid_o rises the cycle after the input transfer, and back-to-back throughput is 1 per cycle while out_ready_i stays high.
REQ-029 out_valid_o SHALL clear after an output transfer if no new input transfer occurs in that same cycle.
REQ-030 While out_valid_o is high and out_ready_i is low, out_o, hit_o and hit_idx_o SHALL hold stable.
REQ-031 A lookup SHALL use the table contents from before any write or clear in the same cycle; the update becomes visible to lookups in the next cycle.
REQ-032 A write with wr_idx_i >= DEPTH SHALL be ignored with no side effect.
REQ-033 When wr_en_i and clr_i are asserted in the same cycle, clr_i SHALL invalidate all entries, then the write SHALL apply to its own entry (write wins).
REQ-034 clr_i SHALL NOT affect the output register or an in-flight result.

Reset
REQ-035 While rst_i is high at a clock edge, the block SHALL clear every valid bit and every mask, value and result field to 0.
REQ-036 While rst_i is high at a clock edge, the block SHALL drive out_valid_o = 0, out_o = MISS_RESULT, hit_o = 0, hit_idx_o = 0.
REQ-037 Reset SHALL take priority over clr_i, wr_en_i and lookups, and a held result SHALL be discarded when reset arrives mid-stall.
REQ-038 in_ready_o SHALL be high in the first cycle after reset deasserts.

Structure
REQ-039 A shared package match_table_pkg SHALL hold the entry struct typedef (vld, mask, value, result) and a helper function computing IDX_W.
REQ-040 Priority selection SHALL be implemented in one sub-module, priority_encoder (one-hot/any-hit in; index and found out), parametrised by width.
REQ-041 Storage SHALL be flops, not a RAM macro, because all entries are compared in parallel every cycle.

Verification
REQ-042 Test: reset, then in_i = 0x082 valid -> one cycle later out_valid_o = 1, hit_o = 0, out_o = MISS_RESULT.
REQ-043 Test: entry1 {mask 0x0C3, value 0x082, result 5}, lookups 0x082 and 0x382 -> hit_o = 1, idx 1, out 5 for both; lookup 0x083 -> miss.
REQ-044 Test: entry0 {mask 0, result 9} and entry1 as above, lookup 0x082 -> idx 0, out 9 (priority and wildcard).
REQ-045 Test: hold out_ready_i low for 3 cycles after a hit -> in_ready_o = 0 and outputs stable; release -> transfer completes and the next input is accepted the same cycle.
REQ-046 Test: in one cycle write entry2 {mask 0x3FF, value 0x155, result 3} and look up 0x155 -> miss; the same lookup in the next cycle -> hit, idx 2, out 3.
REQ-047 Test: clr_i together with a write to entry0 -> only entry0 valid afterwards; rst_i asserted during a stall -> out_valid_o = 0 next cycle and the table is empty.
